// File: rtl/microwave_countdown_pkg.sv
`default_nettype none
// ============================================================================
// Package  : microwave_pkg
// Purpose  : Shared state encodings and BCD constants for the cook countdown.
// Revision : 1.0
// ============================================================================
package microwave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [3:0]  c_bcd_digit_max       = 4'd9;
    localparam logic [3:0]  c_sec_tens_wrap       = 4'd5;
    localparam logic [15:0] c_quick_start_default = 16'h0030;

    function automatic logic is_decimal_digit(input logic [3:0] digit);
        return (digit <= c_bcd_digit_max);
    endfunction

endpackage
`default_nettype wire

// File: rtl/microwave_countdown_bcd_mmss_dec.sv
`default_nettype none
// ============================================================================
// Module   : bcd_mmss_dec
// Purpose  : Combinational one-second decrement of a BCD mm:ss value; 00:00 holds.
// Revision : 1.0
// ============================================================================
module bcd_mmss_dec
    import microwave_pkg::*;
(
    input  logic [15:0] i_time_bcd,
    output logic [15:0] o_time_bcd,
    output logic        o_is_zero
);

    logic [3:0] w_min_tens;
    logic [3:0] w_min_ones;
    logic [3:0] w_sec_tens;
    logic [3:0] w_sec_ones;

    assign o_is_zero = (i_time_bcd == 16'h0000);

    // Each digit borrows only when every digit below it is already zero.
    always_comb begin
        w_min_tens = i_time_bcd[15:12];
        w_min_ones = i_time_bcd[11:8];
        w_sec_tens = i_time_bcd[7:4];
        w_sec_ones = i_time_bcd[3:0];
        if (!o_is_zero) begin
            if (i_time_bcd[3:0] != 4'd0) begin
                w_sec_ones = i_time_bcd[3:0] - 4'd1;
            end else begin
                w_sec_ones = c_bcd_digit_max;
                if (i_time_bcd[7:4] != 4'd0) begin
                    w_sec_tens = i_time_bcd[7:4] - 4'd1;
                end else begin
                    w_sec_tens = c_sec_tens_wrap;
                    if (i_time_bcd[11:8] != 4'd0) begin
                        w_min_ones = i_time_bcd[11:8] - 4'd1;
                    end else begin
                        w_min_ones = c_bcd_digit_max;
                        w_min_tens = i_time_bcd[15:12] - 4'd1;
                    end
                end
            end
        end
    end

    assign o_time_bcd = {w_min_tens, w_min_ones, w_sec_tens, w_sec_ones};

endmodule
`default_nettype wire

// File: rtl/microwave_countdown.sv
`default_nettype none
// ============================================================================
// Module   : microwave_countdown
// Purpose  : Keypad-loaded BCD mm:ss cook timer driven by the 1 Hz second clock.
// Revision : 1.0
// ============================================================================
module microwave_countdown
    import microwave_pkg::*;
#(
    parameter logic [15:0] QUICK_START  = c_quick_start_default,
    parameter int          BEEP_SECONDS = 3
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        clk_1s,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        start,
    input  logic        stop_clear,
    input  logic        door_open,
    output logic [15:0] time_bcd,
    output logic [2:0]  state,
    output logic        heater_on,
    output logic        beep,
    output logic        done
);

    localparam logic [3:0] c_beep_target = 4'(BEEP_SECONDS);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_time_bcd;
    logic [15:0] w_next_time;
    logic [3:0]  r_beep_cnt;
    logic [3:0]  w_next_beep_cnt;
    logic [3:0]  w_beep_cnt_inc;
    logic        r_beep;
    logic        w_next_beep;
    logic        r_done;
    logic        w_next_done;
    logic        r_clk_1s_d;
    logic        w_tick;
    logic        w_key_ok;
    logic        w_start_ok;
    logic [15:0] w_dec_time;
    logic        w_time_zero;

    assign w_tick         = clk_1s & ~r_clk_1s_d;
    assign w_key_ok       = key_valid & is_decimal_digit(key_digit);
    assign w_start_ok     = start & ~door_open;
    assign w_beep_cnt_inc = r_beep_cnt + 4'd1;

    bcd_mmss_dec u_dec (
        .i_time_bcd (r_time_bcd),
        .o_time_bcd (w_dec_time),
        .o_is_zero  (w_time_zero)
    );

    always_comb begin
        w_next_state    = r_state;
        w_next_time     = r_time_bcd;
        w_next_beep_cnt = r_beep_cnt;
        w_next_beep     = r_beep;
        w_next_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (stop_clear) begin
                    w_next_time = 16'h0000;
                end else if (w_start_ok) begin
                    w_next_time  = QUICK_START;
                    w_next_state = ST_RUN;
                end else if (w_key_ok) begin
                    w_next_time  = {12'h000, key_digit};
                    w_next_state = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (stop_clear) begin
                    w_next_time  = 16'h0000;
                    w_next_state = ST_IDLE;
                end else if (w_start_ok && !w_time_zero) begin
                    w_next_state = ST_RUN;
                end else if (w_key_ok) begin
                    w_next_time = {r_time_bcd[11:0], key_digit};
                end
            end
            ST_RUN: begin
                // Door and stop pre-empt a coincident tick so time is frozen.
                if (stop_clear || door_open) begin
                    w_next_state = ST_PAUSE;
                end else if (w_tick) begin
                    w_next_time = w_dec_time;
                    if (w_dec_time == 16'h0000) begin
                        w_next_state    = ST_DONE;
                        w_next_done     = 1'b1;
                        w_next_beep     = 1'b1;
                        w_next_beep_cnt = 4'd0;
                    end
                end
            end
            ST_PAUSE: begin
                if (stop_clear) begin
                    w_next_time  = 16'h0000;
                    w_next_state = ST_IDLE;
                end else if (w_start_ok) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: begin
                w_next_beep = 1'b1;
                if (stop_clear) begin
                    w_next_beep     = 1'b0;
                    w_next_beep_cnt = 4'd0;
                    w_next_state    = ST_IDLE;
                end else if (w_tick) begin
                    if (w_beep_cnt_inc == c_beep_target) begin
                        w_next_beep     = 1'b0;
                        w_next_beep_cnt = 4'd0;
                        w_next_state    = ST_IDLE;
                    end else begin
                        w_next_beep_cnt = w_beep_cnt_inc;
                    end
                end
            end
            default: begin
                w_next_state    = ST_IDLE;
                w_next_beep     = 1'b0;
                w_next_beep_cnt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_time_bcd <= 16'h0000;
            r_beep_cnt <= 4'd0;
            r_beep     <= 1'b0;
            r_done     <= 1'b0;
            r_clk_1s_d <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_time_bcd <= w_next_time;
            r_beep_cnt <= w_next_beep_cnt;
            r_beep     <= w_next_beep;
            r_done     <= w_next_done;
            r_clk_1s_d <= clk_1s;
        end
    end

    assign time_bcd  = r_time_bcd;
    assign state     = r_state;
    assign heater_on = (r_state == ST_RUN);
    assign beep      = r_beep;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_microwave_countdown.sv
`default_nettype none
// ============================================================================
// Module   : tb_microwave_countdown
// Purpose  : Directed self-checking bench for the microwave cook countdown.
// Revision : 1.0
// ============================================================================
module tb_microwave_countdown;

    logic        sys_clk;
    logic        reset;
    logic        clk_1s;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        start;
    logic        stop_clear;
    logic        door_open;
    logic [15:0] time_bcd;
    logic [2:0]  state;
    logic        heater_on;
    logic        beep;
    logic        done;

    int n_assert;
    int n_fail;

    microwave_countdown dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .clk_1s     (clk_1s),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .start      (start),
        .stop_clear (stop_clear),
        .door_open  (door_open),
        .time_bcd   (time_bcd),
        .state      (state),
        .heater_on  (heater_on),
        .beep       (beep),
        .done       (done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic press_key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        cycle();
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    task automatic press_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic press_stop();
        stop_clear = 1'b1;
        cycle();
        stop_clear = 1'b0;
    endtask

    task automatic tick_rise();
        clk_1s = 1'b1;
        cycle();
    endtask

    task automatic tick_fall();
        clk_1s = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic do_tick();
        tick_rise();
        tick_fall();
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        clk_1s     = 1'b0;
        key_valid  = 1'b0;
        key_digit  = 4'd0;
        start      = 1'b0;
        stop_clear = 1'b0;
        door_open  = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        chk("reset_state", {13'd0, state}, 16'd0);
        chk("reset_time", time_bcd, 16'h0000);
        chk("reset_heater", {15'd0, heater_on}, 16'd0);
        chk("reset_beep", {15'd0, beep}, 16'd0);
        chk("reset_done", {15'd0, done}, 16'd0);

        // Start with the door open is ignored in IDLE.
        door_open = 1'b1;
        press_start();
        chk("idle_door_start", {13'd0, state}, 16'd0);
        door_open = 1'b0;
        cycle();

        // Quick start.
        press_start();
        chk("qs_state", {13'd0, state}, 16'd2);
        chk("qs_time", time_bcd, 16'h0030);
        chk("qs_heater", {15'd0, heater_on}, 16'd1);
        do_tick();
        chk("qs_tick1", time_bcd, 16'h0029);
        for (int i = 0; i < 28; i++) do_tick();
        chk("qs_tick29", time_bcd, 16'h0001);
        tick_rise();
        chk("qs_done_state", {13'd0, state}, 16'd4);
        chk("qs_done_pulse", {15'd0, done}, 16'd1);
        chk("qs_done_time", time_bcd, 16'h0000);
        chk("qs_done_beep", {15'd0, beep}, 16'd1);
        chk("qs_done_heater", {15'd0, heater_on}, 16'd0);
        tick_fall();
        chk("qs_done_single", {15'd0, done}, 16'd0);
        do_tick();
        chk("beep_tick1", {15'd0, beep}, 16'd1);
        do_tick();
        chk("beep_tick2", {15'd0, beep}, 16'd1);
        chk("beep_tick2_state", {13'd0, state}, 16'd4);
        do_tick();
        chk("beep_end", {15'd0, beep}, 16'd0);
        chk("beep_end_state", {13'd0, state}, 16'd0);

        // Entry with minute borrow.
        press_key(4'd1);
        chk("entry_state", {13'd0, state}, 16'd1);
        press_key(4'd0);
        press_key(4'd0);
        chk("entry_time", time_bcd, 16'h0100);
        press_start();
        chk("entry_run", {13'd0, state}, 16'd2);
        chk("entry_run_time", time_bcd, 16'h0100);
        do_tick();
        chk("borrow_min", time_bcd, 16'h0059);
        do_tick();
        do_tick();
        chk("borrow_more", time_bcd, 16'h0057);
        press_stop();
        chk("stop1_state", {13'd0, state}, 16'd3);
        chk("stop1_time", time_bcd, 16'h0057);
        do_tick();
        chk("pause_tick_ignored", time_bcd, 16'h0057);
        press_stop();
        chk("stop2_state", {13'd0, state}, 16'd0);
        chk("stop2_time", time_bcd, 16'h0000);

        // Shift overflow and non-decimal key.
        press_key(4'd1);
        press_key(4'd2);
        press_key(4'd3);
        press_key(4'd4);
        press_key(4'd5);
        chk("shift_time", time_bcd, 16'h2345);
        press_key(4'd12);
        chk("bad_key", time_bcd, 16'h2345);
        press_stop();
        chk("entry_clear", time_bcd, 16'h0000);

        // Seconds above 59 count down naturally.
        press_key(4'd9);
        press_key(4'd0);
        press_start();
        do_tick();
        chk("sec90", time_bcd, 16'h0089);
        press_stop();
        press_stop();

        // Door opens on the same cycle as a tick.
        press_key(4'd1);
        press_key(4'd0);
        press_start();
        chk("door_pre", time_bcd, 16'h0010);
        door_open = 1'b1;
        clk_1s    = 1'b1;
        cycle();
        chk("door_state", {13'd0, state}, 16'd3);
        chk("door_time", time_bcd, 16'h0010);
        chk("door_heater", {15'd0, heater_on}, 16'd0);
        clk_1s    = 1'b0;
        door_open = 1'b0;
        cycle();
        press_start();
        chk("door_resume", {13'd0, state}, 16'd2);
        do_tick();
        chk("door_resume_tick", time_bcd, 16'h0009);

        // Stop and start together in PAUSE.
        press_stop();
        chk("pause_again", {13'd0, state}, 16'd3);
        stop_clear = 1'b1;
        start      = 1'b1;
        cycle();
        stop_clear = 1'b0;
        start      = 1'b0;
        chk("stop_over_start", {13'd0, state}, 16'd0);
        chk("stop_over_start_time", time_bcd, 16'h0000);

        // Asynchronous reset between clock edges.
        press_key(4'd4);
        press_key(4'd5);
        press_start();
        chk("pre_reset_heater", {15'd0, heater_on}, 16'd1);
        @(negedge sys_clk);
        reset = 1'b1;
        #1;
        chk("async_heater", {15'd0, heater_on}, 16'd0);
        chk("async_time", time_bcd, 16'h0000);
        chk("async_state", {13'd0, state}, 16'd0);
        cycle();
        reset = 1'b0;
        cycle();
        do_tick();
        chk("post_reset_tick", time_bcd, 16'h0000);
        chk("post_reset_state", {13'd0, state}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
